// File: rtl/ozixe_cfg_pkg.sv
// Shared constants, state encoding and FF mode byte layout for the ozixe
// configuration stream loader.
package ozixe_cfg_pkg;

    localparam logic [7:0] SYNC       = 8'hA5;
    localparam int         WORD_W     = 32;
    localparam int         LUT_INPUTS = 16;
    localparam int         INIT_WORDS = (2 ** LUT_INPUTS) / WORD_W;
    // One extra bit so the discard path can count payload plus trailer.
    localparam int         CNT_W      = $clog2(INIT_WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        RESP,
        DISCARD
    } state_t;

    localparam logic [1:0] ERR_SYNC  = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_CKSUM = 2'd3;

    typedef struct packed {
        logic       gsr;
        logic       lsr_prld;
        logic [1:0] srmode;
        logic       regset_set;
        logic       clk_inv;
        logic [1:0] cemux;
    } ff_mode_t;

endpackage

// File: rtl/ozixe_cfg_cksum.sv
// Running XOR accumulator over a frame; match compares the accumulated
// value against the word currently on the stream.
module ozixe_cfg_cksum #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         upd,
    input  logic [W-1:0] din,
    input  logic [W-1:0] cmp,
    output logic         match
);

    logic [W-1:0] acc;

    always_ff @(posedge clk) begin
        if (clr)       acc <= '0;
        else if (load) acc <= din;
        else if (upd)  acc <= acc ^ din;
    end

    assign match = (acc == cmp);

endmodule

// File: rtl/ozixe_cfg_loader.sv
// Decodes per-cell configuration frames (header, 2048 INIT words, XOR trailer)
// and drives LUT INIT / FF mode write ports plus commit/err pulses.
module ozixe_cfg_loader
    import ozixe_cfg_pkg::*;
#(
    parameter  int N_CELLS = 256,
    localparam int CI_W    = $clog2(N_CELLS)
) (
    input  logic               CLK,
    input  logic               LSR,
    input  logic [31:0]        s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               cfg_we,
    output logic [CI_W+10:0]   cfg_addr,
    output logic [31:0]        cfg_wdata,
    output logic               ff_we,
    output logic [CI_W-1:0]    ff_addr,
    output logic [7:0]         ff_data,
    output logic               commit,
    output logic [CI_W-1:0]    commit_idx,
    output logic               err,
    output logic [1:0]         err_code,
    output logic               busy
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CI_W-1:0]  idx;
    logic [CI_W-1:0]  hdr_idx;
    ff_mode_t         hdr_mode;
    logic             take, sync_ok, in_range;
    logic             cks_load, cks_upd, cks_match;

    assign take     = s_valid & s_ready;
    assign sync_ok  = (s_data[31:24] == SYNC);
    assign in_range = ({1'b0, s_data[23:16]} < 9'(N_CELLS));
    assign hdr_idx  = s_data[16 +: CI_W];
    assign hdr_mode = s_data[15:8];
    assign cks_load = (state == IDLE) && take && sync_ok && in_range;
    assign cks_upd  = (state == PAYLOAD) && take;
    assign busy     = (state != IDLE);

    ozixe_cfg_cksum #(.W(WORD_W)) u_cksum (
        .clk   (CLK),
        .clr   (LSR),
        .load  (cks_load),
        .upd   (cks_upd),
        .din   (s_data),
        .cmp   (s_data),
        .match (cks_match)
    );

    always_ff @(posedge CLK) begin
        if (LSR) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take && sync_ok) state_nx = in_range ? PAYLOAD : DISCARD;
            PAYLOAD: if (take && cnt == CNT_W'(INIT_WORDS - 1)) state_nx = CHECK;
            CHECK:   if (take) state_nx = RESP;
            RESP:    state_nx = IDLE;
            DISCARD: if (take && cnt == CNT_W'(INIT_WORDS)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (LSR) begin
            s_ready    <= 1'b0;
            cfg_we     <= 1'b0;
            cfg_addr   <= '0;
            cfg_wdata  <= '0;
            ff_we      <= 1'b0;
            ff_addr    <= '0;
            ff_data    <= '0;
            commit     <= 1'b0;
            commit_idx <= '0;
            err        <= 1'b0;
            err_code   <= '0;
            cnt        <= '0;
            idx        <= '0;
        end else begin
            // Ready is registered from the next state so it drops exactly in RESP.
            s_ready <= (state_nx != RESP);
            cfg_we  <= 1'b0;
            ff_we   <= 1'b0;
            commit  <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    cnt <= '0;
                    if (!sync_ok) begin
                        err      <= 1'b1;
                        err_code <= ERR_SYNC;
                    end else if (!in_range) begin
                        err      <= 1'b1;
                        err_code <= ERR_RANGE;
                    end else begin
                        idx     <= hdr_idx;
                        ff_we   <= 1'b1;
                        ff_addr <= hdr_idx;
                        ff_data <= hdr_mode;
                    end
                end
                PAYLOAD: if (take) begin
                    cfg_we    <= 1'b1;
                    cfg_addr  <= {idx, cnt[CNT_W-2:0]};
                    cfg_wdata <= s_data;
                    cnt       <= cnt + 1'b1;
                end
                CHECK: if (take) begin
                    if (cks_match) begin
                        commit     <= 1'b1;
                        commit_idx <= idx;
                    end else begin
                        err      <= 1'b1;
                        err_code <= ERR_CKSUM;
                    end
                end
                DISCARD: if (take) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
